st_pop_unit: RTL and testbench



---
 rtl/st_pop_if.sv | 33 +++
 rtl/st_pop_unit.sv | 100 ++++++++++
 tb/tb_st_pop_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/st_pop_if.sv
// Handshake and bus bundle between the POP sequencer and its neighbours
// (decoder request, data-memory read port, register-file/PC/SP write ports).
interface st_pop_if;
  logic        start;
  logic [8:0]  RL;
  logic [15:0] SP_in;
  logic        busy;
  logic        done;
  logic [15:0] dmem_addr;
  logic        dmem_rd;
  logic [31:0] dmem_rdata;
  logic [2:0]  rdest_addr;
  logic        RF_wr;
  logic [31:0] rf_wdata;
  logic        PC_wr;
  logic [15:0] pc_wdata;
  logic [15:0] SP_out;
  logic        SP_wr;

  // Environment side: decoder, data memory and write-port consumers.
  modport master (
    output start, RL, SP_in, dmem_rdata,
    input  busy, done, dmem_addr, dmem_rd, rdest_addr, RF_wr, rf_wdata,
           PC_wr, pc_wdata, SP_out, SP_wr
  );

  // Sequencer side.
  modport slave (
    input  start, RL, SP_in, dmem_rdata,
    output busy, done, dmem_addr, dmem_rd, rdest_addr, RF_wr, rf_wdata,
           PC_wr, pc_wdata, SP_out, SP_wr
  );
endinterface

// File: rtl/st_pop_unit.sv
// Multi-cycle POP sequencer: one ascending read per listed register, then SP update.
// Define ST_POP_PC_EN to honour RL[8] (PC load from stack); otherwise RL[8] is ignored.
module st_pop_unit (
  input  logic     clk,
  input  logic     reset,
  st_pop_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

`ifdef ST_POP_PC_EN
  localparam logic [8:0] RL_MASK = 9'h1FF;
`else
  localparam logic [8:0] RL_MASK = 9'h0FF;
`endif

  state_t      state;
  logic [8:0]  pending_p0;
  logic [15:0] addr_p0;
  logic [3:0]  wb_k_p1;
  logic        vld_p1;

  logic [8:0]  rl_masked;
  logic [3:0]  issue_k;
  logic [8:0]  pending_nxt;
  logic        issuing;
  logic        rf_wr;
  logic        pc_wr;
  logic        fin;

  function automatic logic [3:0] lowest_bit(input logic [8:0] v);
    lowest_bit = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (v[i]) lowest_bit = 4'(i);
    end
  endfunction

  always_comb begin
    rl_masked   = bus.RL & RL_MASK;
    issue_k     = lowest_bit(pending_p0);
    pending_nxt = pending_p0 & ~(9'd1 << issue_k);
  end

  // Control: state and writeback-valid are the only reset registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      case (state)
        IDLE:    if (bus.start) state <= (rl_masked != 9'd0) ? ISSUE : FIN;
        ISSUE: begin
          vld_p1 <= 1'b1;
          if (pending_nxt == 9'd0) state <= DRAIN;
        end
        DRAIN:   state <= FIN;
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: issue bookkeeping; the issued index rides to writeback.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      pending_p0 <= rl_masked;
      addr_p0    <= bus.SP_in;
    end else if (state == ISSUE) begin
      pending_p0 <= pending_nxt;
      addr_p0    <= addr_p0 + 16'd4;
      wb_k_p1    <= issue_k;
    end
  end

  // Outputs are state decodes; data buses read zero whenever their strobe is low.
  always_comb begin
    issuing = (state == ISSUE);
    fin     = (state == FIN);
    rf_wr   = vld_p1 && !wb_k_p1[3];
`ifdef ST_POP_PC_EN
    pc_wr   = vld_p1 && wb_k_p1[3];
`else
    pc_wr   = 1'b0;
`endif
  end

  assign bus.busy       = (state != IDLE);
  assign bus.dmem_rd    = issuing;
  assign bus.dmem_addr  = issuing ? addr_p0 : 16'd0;
  assign bus.RF_wr      = rf_wr;
  assign bus.rdest_addr = rf_wr ? wb_k_p1[2:0] : 3'd0;
  assign bus.rf_wdata   = rf_wr ? bus.dmem_rdata : 32'd0;
  assign bus.PC_wr      = pc_wr;
  assign bus.pc_wdata   = pc_wr ? bus.dmem_rdata[15:0] : 16'd0;
  assign bus.done       = fin;
  assign bus.SP_wr      = fin;
  assign bus.SP_out     = fin ? addr_p0 : 16'd0;

endmodule

// File: tb/tb_st_pop_unit.sv
// Directed bench for st_pop_unit: cycle-exact checks of reads, writebacks and SP update.
module tb_st_pop_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  st_pop_if bus ();

  st_pop_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef ST_POP_PC_EN
  localparam bit PC_EN = 1'b1;
`else
  localparam bit PC_EN = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] mem [logic [15:0]];

  function automatic logic [31:0] mem_val(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return {~a, a};
  endfunction

  // Data memory with one-cycle read latency.
  always @(posedge clk) bus.dmem_rdata <= bus.dmem_rd ? mem_val(bus.dmem_addr) : 32'h0;

  task automatic check_idle(input string tag);
    chk({tag, ".busy"},  bus.busy, 0);
    chk({tag, ".done"},  bus.done, 0);
    chk({tag, ".rd"},    bus.dmem_rd, 0);
    chk({tag, ".addr"},  bus.dmem_addr, 0);
    chk({tag, ".rfwr"},  bus.RF_wr, 0);
    chk({tag, ".rdest"}, bus.rdest_addr, 0);
    chk({tag, ".rfd"},   bus.rf_wdata, 0);
    chk({tag, ".pcwr"},  bus.PC_wr, 0);
    chk({tag, ".pcd"},   bus.pc_wdata, 0);
    chk({tag, ".spwr"},  bus.SP_wr, 0);
    chk({tag, ".spo"},   bus.SP_out, 0);
  endtask

  // Entered at a negedge with the unit idle; leaves at the negedge after done.
  task automatic run_pop(input string name, input logic [8:0] rl, input logic [15:0] sp,
                         input logic [15:0] exp_sp, input int exp_last, input int glitch_cyc);
    logic [8:0]  eff;
    int          bits[$];
    int          n;
    logic        e_rd, e_rf, e_pc, e_done;
    logic [15:0] e_addr, wa, e_pcd, e_sp;
    logic [2:0]  e_dest;
    logic [31:0] e_rfd, word;
    string       t;
    eff = PC_EN ? rl : (rl & 9'h0FF);
    for (int i = 0; i < 9; i++) if (eff[i]) bits.push_back(i);
    n = bits.size();
    bus.start = 1'b1;
    bus.RL    = rl;
    bus.SP_in = sp;
    for (int c = 1; c <= exp_last; c++) begin
      @(negedge clk);
      if (c == 1 || c == glitch_cyc + 1) bus.start = 1'b0;
      e_rd   = (c <= n);
      e_addr = e_rd ? sp + 16'(4 * (c - 1)) : 16'h0;
      e_rf = 1'b0; e_pc = 1'b0; e_dest = 3'd0; e_rfd = 32'h0; e_pcd = 16'h0;
      if (c >= 2 && c <= n + 1) begin
        wa   = sp + 16'(4 * (c - 2));
        word = mem_val(wa);
        if (bits[c-2] < 8) begin
          e_rf = 1'b1; e_dest = 3'(bits[c-2]); e_rfd = word;
        end else begin
          e_pc = 1'b1; e_pcd = word[15:0];
        end
      end
      e_done = (c == exp_last);
      e_sp   = e_done ? exp_sp : 16'h0;
      t = $sformatf("%s.c%0d", name, c);
      chk({t, ".busy"},  bus.busy, 1);
      chk({t, ".rd"},    bus.dmem_rd, e_rd);
      chk({t, ".addr"},  bus.dmem_addr, e_addr);
      chk({t, ".rfwr"},  bus.RF_wr, e_rf);
      chk({t, ".rdest"}, bus.rdest_addr, e_dest);
      chk({t, ".rfd"},   bus.rf_wdata, e_rfd);
      chk({t, ".pcwr"},  bus.PC_wr, e_pc);
      chk({t, ".pcd"},   bus.pc_wdata, e_pcd);
      chk({t, ".done"},  bus.done, e_done);
      chk({t, ".spwr"},  bus.SP_wr, e_done);
      chk({t, ".spo"},   bus.SP_out, e_sp);
      if (c == glitch_cyc) begin
        bus.start = 1'b1;
        bus.RL    = 9'h003;
        bus.SP_in = 16'h1234;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    check_idle({name, ".after"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    mem[16'h0100] = 32'hAAAA0001;
    mem[16'h0104] = 32'hBBBB0002;
    mem[16'h0204] = 32'h00001234;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.RL    = 9'h0;
    bus.SP_in = 16'h0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);

    run_pop("two_regs", 9'h003, 16'h0100, 16'h0108, 4, 0);
    run_pop("r7_pc",    9'h180, 16'h0200, PC_EN ? 16'h0208 : 16'h0204, PC_EN ? 4 : 3, 0);
    run_pop("empty",    9'h000, 16'h0300, 16'h0300, 1, 0);
    run_pop("wrap",     9'h0FF, 16'hFFF8, 16'h0018, 10, 2);
    run_pop("fin_start", 9'h014, 16'h0500, 16'h0508, 4, 4);
    run_pop("pc_only",  9'h100, 16'h0600, PC_EN ? 16'h0604 : 16'h0600, PC_EN ? 3 : 1, 0);

    // Abort: reset sampled at the end of cycle 2 of a four-register POP.
    bus.start = 1'b1;
    bus.RL    = 9'h00F;
    bus.SP_in = 16'h0400;
    @(negedge clk);
    bus.start = 1'b0;
    chk("abort.c1.rd",   bus.dmem_rd, 1);
    chk("abort.c1.addr", bus.dmem_addr, 16'h0400);
    @(negedge clk);
    chk("abort.c2.rfwr", bus.RF_wr, 1);
    chk("abort.c2.rfd",  bus.rf_wdata, {16'hFBFF, 16'h0400});
    chk("abort.c2.addr", bus.dmem_addr, 16'h0404);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("abort.c3");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("abort.post%0d.done", i), bus.done, 0);
      chk($sformatf("abort.post%0d.rd", i), bus.dmem_rd, 0);
      chk($sformatf("abort.post%0d.rfwr", i), bus.RF_wr, 0);
    end

    run_pop("after_abort", 9'h00F, 16'h0400, 16'h0410, 6, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
